// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: FSM states,
// opcode constants, datapath select encodings and the control word layout.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_LUI       = 4'd8,
      S_ALU_WB    = 4'd9,
      S_BRANCH    = 4'd10,
      S_JAL       = 4'd11,
      S_JALR_ADDR = 4'd12,
      S_JALR_JUMP = 4'd13,
      S_ERROR     = 4'd15
   } state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;
   localparam logic [1:0] SRC_A_ZERO  = 2'b11;

   localparam logic [1:0] SRC_B_RS2   = 2'b00;
   localparam logic [1:0] SRC_B_IMM   = 2'b01;
   localparam logic [1:0] SRC_B_FOUR  = 2'b10;

   localparam logic [1:0] ALU_OP_ADD  = 2'b00;
   localparam logic [1:0] ALU_OP_SUB  = 2'b01;
   localparam logic [1:0] ALU_OP_R    = 2'b10;
   localparam logic [1:0] ALU_OP_I    = 2'b11;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // One bundle of every control output except bus_err.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [2:0] imm_src;
      logic [1:0] result_src;
   } ctrl_t;

   // States that hold a memory request open and are watched by the watchdog.
   function automatic logic is_req_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Branch condition evaluation from funct3 and the ALU flags of RS1-RS2.
// Unsigned compares and reserved funct3 values resolve to not-taken.
module branch_cond
   import multicycle_controller_pkg::*;
(
   input  logic [2:0] f3,
   input  logic       zero,
   input  logic       neg,
   output logic       taken
);

   // Pure decode of funct3 against the subtract flags.
   always_comb begin
      taken = 1'b0;
      case (f3)
         3'b000:  taken = zero;   // BEQ
         3'b001:  taken = ~zero;  // BNE
         3'b100:  taken = neg;    // BLT
         3'b101:  taken = ~neg;   // BGE
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main controller: Moore FSM over a shared ALU and one
// unified memory port with a req/ready handshake, plus a memory watchdog.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap to ERROR
// instead of retiring as a NOP.
//
// Handshake: mem_req is held with a stable address and mem_we until the
// cycle in which mem_ready is 1; that cycle completes the transfer and the
// FSM advances on the next edge. mem_ready while mem_req is 0 is ignored.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opc,
   input  logic [2:0] f3,
   input  logic       zero,
   input  logic       neg,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [2:0] imm_src,
   output logic [1:0] result_src,
   output logic       bus_err,
   output logic [3:0] state_dbg
);

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_e           state;
   logic [CNT_W-1:0] wd_cnt;
   logic             err_q;
   logic             taken;
   logic             in_req;
   logic             wd_expire;
   ctrl_t            ctrl;

   branch_cond u_branch_cond (
      .f3    (f3),
      .zero  (zero),
      .neg   (neg),
      .taken (taken)
   );

   assign in_req    = is_req_state(state);
   // Ready arriving on the last allowed cycle still completes the transfer.
   assign wd_expire = (MEM_TIMEOUT != 0) && in_req && !mem_ready && (wd_cnt == WD_LAST);

   // State sequencing, watchdog counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_FETCH;
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (in_req && !mem_ready) wd_cnt <= wd_cnt + CNT_W'(1);
         else                      wd_cnt <= '0;

         if (wd_expire) begin
            state  <= S_ERROR;
            err_q  <= 1'b1;
            wd_cnt <= '0;
         end else begin
            case (state)
               S_FETCH:     if (mem_ready) state <= S_DECODE;
               S_DECODE: begin
                  case (opc)
                     OPC_LOAD, OPC_STORE: state <= S_MEM_ADDR;
                     OPC_RTYPE:           state <= S_EXEC_R;
                     OPC_ITYPE:           state <= S_EXEC_I;
                     OPC_BRANCH:          state <= S_BRANCH;
                     OPC_JAL:             state <= S_JAL;
                     OPC_JALR:            state <= S_JALR_ADDR;
                     OPC_LUI:             state <= S_LUI;
                     default: begin
`ifdef ILLEGAL_TRAP_EN
                        state <= S_ERROR;
                        err_q <= 1'b1;
`else
                        // PC was already advanced in FETCH, so this retires as a NOP.
                        state <= S_FETCH;
`endif
                     end
                  endcase
               end
               S_MEM_ADDR:  state <= (opc == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
               S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
               S_MEM_WB:    state <= S_FETCH;
               S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
               S_EXEC_R, S_EXEC_I, S_LUI, S_JAL, S_JALR_JUMP: state <= S_ALU_WB;
               S_ALU_WB:    state <= S_FETCH;
               S_BRANCH:    state <= S_FETCH;
               S_JALR_ADDR: state <= S_JALR_JUMP;
               S_ERROR:     state <= S_ERROR;
               default:     state <= S_FETCH;
            endcase
         end
      end
   end

   // Moore output decode; only FETCH write enables and BRANCH pc_write look at inputs.
   always_comb begin
      ctrl = '0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               ctrl.mem_req    = 1'b1;
               ctrl.alu_src_a  = SRC_A_PC;
               ctrl.alu_src_b  = SRC_B_FOUR;
               ctrl.result_src = RES_ALU;
               ctrl.ir_write   = mem_ready;
               ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
               ctrl.alu_src_a = SRC_A_OLDPC;
               ctrl.alu_src_b = SRC_B_IMM;
               ctrl.imm_src   = (opc == OPC_JAL) ? IMM_J : IMM_B;
            end
            S_MEM_ADDR: begin
               ctrl.alu_src_a = SRC_A_RS1;
               ctrl.alu_src_b = SRC_B_IMM;
               ctrl.imm_src   = (opc == OPC_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_READ: begin
               ctrl.mem_req = 1'b1;
               ctrl.adr_src = 1'b1;
            end
            S_MEM_WB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.result_src = RES_MEM;
            end
            S_MEM_WRITE: begin
               ctrl.mem_req = 1'b1;
               ctrl.mem_we  = 1'b1;
               ctrl.adr_src = 1'b1;
            end
            S_EXEC_R: begin
               ctrl.alu_src_a = SRC_A_RS1;
               ctrl.alu_src_b = SRC_B_RS2;
               ctrl.alu_op    = ALU_OP_R;
            end
            S_EXEC_I: begin
               ctrl.alu_src_a = SRC_A_RS1;
               ctrl.alu_src_b = SRC_B_IMM;
               ctrl.alu_op    = ALU_OP_I;
               ctrl.imm_src   = IMM_I;
            end
            S_LUI: begin
               ctrl.alu_src_a = SRC_A_ZERO;
               ctrl.alu_src_b = SRC_B_IMM;
               ctrl.imm_src   = IMM_U;
            end
            S_ALU_WB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.result_src = RES_ALUOUT;
            end
            S_BRANCH: begin
               ctrl.alu_src_a  = SRC_A_RS1;
               ctrl.alu_src_b  = SRC_B_RS2;
               ctrl.alu_op     = ALU_OP_SUB;
               ctrl.result_src = RES_ALUOUT;
               ctrl.pc_write   = taken;
            end
            S_JAL, S_JALR_JUMP: begin
               // ALUOut holds the target; the ALU forms OldPC+4 for ALU_WB.
               ctrl.alu_src_a  = SRC_A_OLDPC;
               ctrl.alu_src_b  = SRC_B_FOUR;
               ctrl.result_src = RES_ALUOUT;
               ctrl.pc_write   = 1'b1;
            end
            S_JALR_ADDR: begin
               ctrl.alu_src_a = SRC_A_RS1;
               ctrl.alu_src_b = SRC_B_IMM;
               ctrl.imm_src   = IMM_I;
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign mem_req    = ctrl.mem_req;
   assign mem_we     = ctrl.mem_we;
   assign adr_src    = ctrl.adr_src;
   assign ir_write   = ctrl.ir_write;
   assign pc_write   = ctrl.pc_write;
   assign reg_write  = ctrl.reg_write;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign imm_src    = ctrl.imm_src;
   assign result_src = ctrl.result_src;
   assign bus_err    = err_q & ~rst;
   assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle traces built from
// the instruction semantics, pushed into an expected queue by the driver and
// popped by a negedge monitor comparing the whole control word.
module tb_multicycle_controller;

   localparam int W   = 18;
   localparam int TMO = 4;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] IT   = 7'b0010011;
   localparam logic [6:0] BT   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] BAD  = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opc = '0;
   logic [2:0] f3 = '0;
   logic       zero = 1'b0;
   logic       neg = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, bus_err;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic [2:0] imm_src;
   logic [3:0] state_dbg;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp, mon_act;
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .opc(opc), .f3(f3), .zero(zero), .neg(neg),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .imm_src(imm_src), .result_src(result_src), .bus_err(bus_err),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Control word: req we adr irw pcw rw | a b op | imm | res | err
   function automatic logic [W-1:0] vec(input logic req, we, adr, irw, pcw, rw,
                                        input logic [1:0] a, b, op,
                                        input logic [2:0] imm,
                                        input logic [1:0] res,
                                        input logic err);
      return {req, we, adr, irw, pcw, rw, a, b, op, imm, res, err};
   endfunction

   // Branch outcome from comparison semantics of RS1-RS2 flags.
   function automatic logic br_taken(input logic [2:0] fn, input logic z, input logic n);
      logic eq, lt;
      eq = z;
      lt = n;
      case (fn)
         3'd0:    return eq;
         3'd1:    return !eq;
         3'd4:    return lt;
         3'd5:    return !lt;
         default: return 1'b0;
      endcase
   endfunction

   // driver tasks
   task automatic cycle(input logic rdy, input logic [W-1:0] e);
      mem_ready = rdy;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_cycles(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) cycle(1'($urandom_range(0, 1)), '0);
      rst = 1'b0;
   endtask

   // A request phase: stalls < TMO then a ready cycle, or TMO dead cycles.
   task automatic req_phase(input logic [W-1:0] v_wait, input logic [W-1:0] v_done,
                            input int stalls, output bit ok);
      if (stalls >= TMO) begin
         for (int i = 0; i < TMO; i++) cycle(1'b0, v_wait);
         ok = 1'b0;
      end else begin
         for (int i = 0; i < stalls; i++) cycle(1'b0, v_wait);
         cycle(1'b1, v_done);
         ok = 1'b1;
      end
   endtask

   task automatic error_tail();
      for (int i = 0; i < 3; i++) cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,0,0,0,0,0,0,0,1));
      reset_cycles(1);
   endtask

   task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3_i,
                            input logic z_i, input logic n_i,
                            input int fs, input int ms);
      bit ok;
      logic [W-1:0] alu_wb;
      logic [W-1:0] mr, mw;
      alu_wb = vec(0,0,0,0,0,1, 2'd0,2'd0,2'd0,3'd0,2'd0,0);
      mr     = vec(1,0,1,0,0,0, 2'd0,2'd0,2'd0,3'd0,2'd0,0);
      mw     = vec(1,1,1,0,0,0, 2'd0,2'd0,2'd0,3'd0,2'd0,0);
      opc = op_i; f3 = f3_i; zero = z_i; neg = n_i;
      req_phase(vec(1,0,0,0,0,0, 2'd0,2'd2,2'd0,3'd0,2'd2,0),
                vec(1,0,0,1,1,0, 2'd0,2'd2,2'd0,3'd0,2'd2,0), fs, ok);
      if (!ok) begin error_tail(); return; end
      cycle(1'($urandom_range(0, 1)),
            vec(0,0,0,0,0,0, 2'd1,2'd1,2'd0,(op_i == JAL) ? 3'd4 : 3'd2,2'd0,0));
      case (op_i)
         LW: begin
            cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,0,0, 2'd2,2'd1,2'd0,3'd0,2'd0,0));
            req_phase(mr, mr, ms, ok);
            if (!ok) begin error_tail(); return; end
            cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,0,1, 2'd0,2'd0,2'd0,3'd0,2'd1,0));
         end
         SW: begin
            cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,0,0, 2'd2,2'd1,2'd0,3'd1,2'd0,0));
            req_phase(mw, mw, ms, ok);
            if (!ok) begin error_tail(); return; end
         end
         RT: begin
            cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,0,0, 2'd2,2'd0,2'd2,3'd0,2'd0,0));
            cycle(1'($urandom_range(0, 1)), alu_wb);
         end
         IT: begin
            cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,0,0, 2'd2,2'd1,2'd3,3'd0,2'd0,0));
            cycle(1'($urandom_range(0, 1)), alu_wb);
         end
         LUI: begin
            cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,0,0, 2'd3,2'd1,2'd0,3'd3,2'd0,0));
            cycle(1'($urandom_range(0, 1)), alu_wb);
         end
         BT: begin
            cycle(1'($urandom_range(0, 1)),
                  vec(0,0,0,0,br_taken(f3_i, z_i, n_i),0, 2'd2,2'd0,2'd1,3'd0,2'd0,0));
         end
         JAL: begin
            cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,1,0, 2'd1,2'd2,2'd0,3'd0,2'd0,0));
            cycle(1'($urandom_range(0, 1)), alu_wb);
         end
         JALR: begin
            cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,0,0, 2'd2,2'd1,2'd0,3'd0,2'd0,0));
            cycle(1'($urandom_range(0, 1)), vec(0,0,0,0,1,0, 2'd1,2'd2,2'd0,3'd0,2'd0,0));
            cycle(1'($urandom_range(0, 1)), alu_wb);
         end
         default: begin
`ifdef ILLEGAL_TRAP_EN
            error_tail();
`endif
         end
      endcase
   endtask

   // Store that is aborted by reset while waiting in MEM_WRITE.
   task automatic sw_abort();
      opc = SW; f3 = 3'd2;
      cycle(1'b1, vec(1,0,0,1,1,0, 2'd0,2'd2,2'd0,3'd0,2'd2,0));
      cycle(1'b0, vec(0,0,0,0,0,0, 2'd1,2'd1,2'd0,3'd2,2'd0,0));
      cycle(1'b0, vec(0,0,0,0,0,0, 2'd2,2'd1,2'd0,3'd1,2'd0,0));
      cycle(1'b0, vec(1,1,1,0,0,0, 2'd0,2'd0,2'd0,3'd0,2'd0,0));
      reset_cycles(1);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, alu_op, imm_src, result_src, bus_err};
         n_checks++;
         if (mon_act === mon_exp) n_pass++;
         else $display("FAIL ctrl_word cyc=%0d got=%h exp=%h", cyc, mon_act, mon_exp);
      end
   end

   // stimulus and final report
   initial begin
      logic [6:0] opc_tab [10];
      opc_tab = '{LW, SW, RT, IT, BT, JAL, JALR, LUI, BAD, 7'b0000000};
      @(posedge clk);
      #1;
      reset_cycles(2);
      run_instr(RT, 3'd0, 1'b0, 1'b0, 0, 0);   // ADD
      run_instr(LW, 3'd2, 1'b0, 1'b0, 0, 3);   // LW with 3 stall cycles
      run_instr(BT, 3'd0, 1'b1, 1'b0, 0, 0);   // BEQ taken
      run_instr(BT, 3'd1, 1'b1, 1'b0, 0, 0);   // BNE not taken
      run_instr(BT, 3'd5, 1'b0, 1'b0, 0, 0);   // BGE taken
      run_instr(JALR, 3'd0, 1'b0, 1'b0, 0, 0);
      run_instr(RT, 3'd0, 1'b0, 1'b0, TMO, 0); // fetch watchdog expiry
      run_instr(RT, 3'd0, 1'b0, 1'b0, TMO - 1, 0); // ready on last cycle
      run_instr(BAD, 3'd0, 1'b0, 1'b0, 0, 0);
      run_instr(SW, 3'd2, 1'b0, 1'b0, 1, TMO); // write watchdog expiry
      sw_abort();
      run_instr(JAL, 3'd0, 1'b0, 1'b0, 0, 0);
      for (int k = 0; k < 150; k++) begin
         int fs, ms;
         fs = ($urandom_range(0, 29) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
         ms = ($urandom_range(0, 29) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
         run_instr(opc_tab[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fs, ms);
      end
      repeat (3) @(posedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
